// File: rtl/regfile_scb.sv
// regfile_scb: integer register file with NUM_RD independent combinational read
// ports and a per-register pending (scoreboard) bit for the issue stage.
// x0 reads as zero and is never pending.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a read of the
// register being written this cycle returns the write data and reports not busy.
module regfile_scb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]        o_rs_busy,
  input  logic                     i_rd_wren,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [DATA_W-1:0]        i_rd_data,
  input  logic                     i_alloc_valid,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  output logic                     o_alloc_ready,
  input  logic                     i_flush,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  // Entry 0 is reset and never written, so it stays zero and is pruned.
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [CNT_W-1:0]  busy_cnt;

  logic wr_en;
  logic alloc_pend;
  logic alloc_ready;
  logic alloc_set;
  logic cnt_inc;
  logic cnt_dec;

  logic [ADDR_W-1:0] rs_addr [NUM_RD];
  logic [NUM_RD-1:0] byp_hit;

  // Handshake and scoreboard-count bookkeeping for the current cycle.
  always_comb begin
    wr_en       = i_rd_wren && (i_rd_addr != '0);
    alloc_pend  = pend[i_alloc_addr];
    // Ready never looks at i_alloc_valid, so valid has no path to any output.
    alloc_ready = !i_flush &&
                  (!alloc_pend || (i_rd_wren && (i_rd_addr == i_alloc_addr)));
    alloc_set   = i_alloc_valid && alloc_ready && (i_alloc_addr != '0);
    // Count tracks the population of pend: +1 only on a 0->1 transition,
    // -1 only when a write clears a set bit that an alloc is not re-setting.
    cnt_inc     = alloc_set && !alloc_pend;
    cnt_dec     = wr_en && pend[i_rd_addr] &&
                  !(alloc_set && (i_alloc_addr == i_rd_addr));
  end

  // Register storage: writes to x0 are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[i_rd_addr] <= i_rd_data;
    end
  end

  // Pending bits: write clears, accepted alloc sets (alloc wins on a tie),
  // flush clears everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend <= '0;
    end else if (i_flush) begin
      pend <= '0;
    end else begin
      if (wr_en) begin
        pend[i_rd_addr] <= 1'b0;
      end
      if (alloc_set) begin
        pend[i_alloc_addr] <= 1'b1;
      end
    end
  end

  // Registered count of pending registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_cnt <= '0;
    end else if (i_flush) begin
      busy_cnt <= '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt <= busy_cnt + CNT_W'(1);
        2'b01:   busy_cnt <= busy_cnt - CNT_W'(1);
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  // Unpack read addresses and decide per-port forwarding.
  always_comb begin
    byp_hit = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rs_addr[k] = i_rs_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      // Gated by reset so reads stay zero while reset is held.
      byp_hit[k] = !i_rst && wr_en && (i_rd_addr == rs_addr[k]);
`endif
    end
  end

  // Combinational read ports.
  always_comb begin
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (rs_addr[k] == '0) begin
        o_rs_data[k*DATA_W +: DATA_W] = '0;
        o_rs_busy[k]                  = 1'b0;
      end else if (byp_hit[k]) begin
        o_rs_data[k*DATA_W +: DATA_W] = i_rd_data;
        o_rs_busy[k]                  = 1'b0;
      end else begin
        o_rs_data[k*DATA_W +: DATA_W] = regs[rs_addr[k]];
        o_rs_busy[k]                  = pend[rs_addr[k]];
      end
    end
  end

  assign o_alloc_ready = alloc_ready;
  assign o_busy_cnt    = busy_cnt;

endmodule

// File: tb/tb_regfile_scb.sv
// tb_regfile_scb: directed scenarios plus randomized traffic for regfile_scb,
// checked against an array-based reference model of the register file.
module tb_regfile_scb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 3;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD*DW-1:0]    rs_data;
  logic [NRD-1:0]       rs_busy;
  logic                 wren;
  logic [AW-1:0]        rd_addr;
  logic [DW-1:0]        rd_data;
  logic                 alloc_valid;
  logic [AW-1:0]        alloc_addr;
  logic                 alloc_ready;
  logic                 flush;
  logic [AW:0]          busy_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];
  bit            last_acc;

  regfile_scb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data),
    .o_rs_busy    (rs_busy),
    .i_rd_wren    (wren),
    .i_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .i_alloc_valid(alloc_valid),
    .i_alloc_addr (alloc_addr),
    .o_alloc_ready(alloc_ready),
    .i_flush      (flush),
    .o_busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic bit bypass_hit(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return !rst && wren && (rd_addr != 0) && (rd_addr == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (rst || a == 0) return '0;
    if (bypass_hit(a)) return rd_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (rst || a == 0) return 1'b0;
    if (bypass_hit(a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic exp_ready();
    if (flush) return 1'b0;
    if (alloc_addr == 0) return 1'b1;
    return !m_pend[alloc_addr] || (wren && rd_addr == alloc_addr);
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [AW-1:0] port_addr(input int k);
    return rs_addr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] port_data(input int k);
    return rs_data[k*DW +: DW];
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("rd%0d_data", k), 64'(port_data(k)), 64'(exp_data(port_addr(k))));
      check($sformatf("rd%0d_busy", k), 64'(rs_busy[k]), 64'(exp_busy(port_addr(k))));
    end
    check("alloc_ready", 64'(alloc_ready), 64'(exp_ready()));
    check("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
  endtask

  // One clock: check at the falling edge, apply the edge to the model,
  // return 1 ns after the rising edge so the caller can set new inputs.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    check_outputs();
    acc = alloc_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (wren && rd_addr != 0) begin
        m_mem[rd_addr]  = rd_data;
        m_pend[rd_addr] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
      end
      if (acc && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic idle();
    wren        = 1'b0;
    rd_addr     = '0;
    rd_data     = '0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    flush       = 1'b0;
  endtask

  task automatic read_all(input logic [AW-1:0] a);
    for (int k = 0; k < NRD; k++) rs_addr[k*AW +: AW] = a;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren = 1'b1; rd_addr = a; rd_data = d;
  endtask

  task automatic do_alloc(input logic [AW-1:0] a);
    alloc_valid = 1'b1; alloc_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    last_acc = 1'b0;
    model_clear();
    idle();
    read_all(5'd3);
    // Reset held while a write is presented.
    do_write(5'd3, 32'hCAFEF00D);
    cycle();
    cycle();
    check("rst_data", 64'(port_data(0)), 64'h0);
    check("rst_cnt", 64'(busy_cnt), 64'h0);
    check("rst_ready", 64'(alloc_ready), 64'h1);
    rst = 1'b0;
    idle();

    // Basic write then read.
    do_write(5'd5, 32'hDEADBEEF);
    cycle();
    idle();
    read_all(5'd5);
    #1;
    check("x5_read", 64'(port_data(0)), 64'hDEADBEEF);
    cycle();

    // x0 never stores and never becomes pending.
    do_write(5'd0, 32'hFFFFFFFF);
    cycle();
    idle();
    do_alloc(5'd0);
    read_all(5'd0);
    cycle();
    idle();
    #1;
    check("x0_data", 64'(port_data(1)), 64'h0);
    check("x0_busy", 64'(rs_busy[1]), 64'h0);
    check("x0_cnt", 64'(busy_cnt), 64'h0);
    cycle();

    // Reservation, refusal, release.
    do_alloc(5'd7);
    read_all(5'd7);
    cycle();
    #1;
    check("x7_busy", 64'(rs_busy[0]), 64'h1);
    check("x7_cnt", 64'(busy_cnt), 64'h1);
    check("x7_refuse", 64'(alloc_ready), 64'h0);
    cycle();
    idle();
    do_write(5'd7, 32'h12);
    cycle();
    idle();
    #1;
    check("x7_clear_busy", 64'(rs_busy[0]), 64'h0);
    check("x7_clear_cnt", 64'(busy_cnt), 64'h0);
    check("x7_data", 64'(port_data(2)), 64'h12);
    cycle();

    // Same-cycle write and alloc on a pending register.
    do_alloc(5'd9);
    read_all(5'd9);
    cycle();
    do_write(5'd9, 32'h34);
    #1;
    check("x9_ready", 64'(alloc_ready), 64'h1);
    cycle();
    idle();
    #1;
    check("x9_data", 64'(port_data(0)), 64'h34);
    check("x9_busy", 64'(rs_busy[0]), 64'h1);
    check("x9_cnt", 64'(busy_cnt), 64'h1);
    cycle();

    // Flush with a concurrent refused alloc and a write that must land.
    for (int r = 1; r <= 4; r++) begin
      do_alloc(AW'(r));
      cycle();
    end
    idle();
    #1;
    check("pre_flush_cnt", 64'(busy_cnt), 64'h5);
    flush = 1'b1;
    do_alloc(5'd6);
    do_write(5'd2, 32'h55);
    #1;
    check("flush_refuse", 64'(alloc_ready), 64'h0);
    cycle();
    idle();
    rs_addr[0 +: AW]  = 5'd6;
    rs_addr[AW +: AW] = 5'd2;
    rs_addr[2*AW +: AW] = 5'd9;
    #1;
    check("flush_x6_busy", 64'(rs_busy[0]), 64'h0);
    check("flush_x2_data", 64'(port_data(1)), 64'h55);
    check("flush_x9_busy", 64'(rs_busy[2]), 64'h0);
    check("flush_cnt", 64'(busy_cnt), 64'h0);
    cycle();

    // Write visibility on every port, with x10 pending beforehand.
    do_alloc(5'd10);
    cycle();
    idle();
    read_all(5'd10);
    do_write(5'd10, 32'hA5A5A5A5);
    #1;
    for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_BYPASS_EN
      check($sformatf("byp%0d_data", k), 64'(port_data(k)), 64'hA5A5A5A5);
      check($sformatf("byp%0d_busy", k), 64'(rs_busy[k]), 64'h0);
`else
      check($sformatf("byp%0d_data", k), 64'(port_data(k)), 64'h0);
      check($sformatf("byp%0d_busy", k), 64'(rs_busy[k]), 64'h1);
`endif
    end
    cycle();
    idle();
    #1;
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("post%0d_data", k), 64'(port_data(k)), 64'hA5A5A5A5);
    end
    cycle();

    // Reset asserted mid-operation clears state immediately.
    do_alloc(5'd11);
    cycle();
    do_write(5'd5, 32'h1);
    read_all(5'd5);
    rst = 1'b1;
    model_clear();
    #1;
    check("midrst_data", 64'(port_data(0)), 64'h0);
    check("midrst_cnt", 64'(busy_cnt), 64'h0);
    cycle();
    rst = 1'b0;
    idle();
    cycle();

    // Randomized traffic; an unaccepted alloc is held stable.
    last_acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!(alloc_valid && !last_acc)) begin
        alloc_valid = ($urandom_range(0, 2) != 0);
        alloc_addr  = AW'($urandom_range(0, DEPTH - 1));
      end
      wren    = ($urandom_range(0, 1) == 1);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) rd_addr = alloc_addr;
      rd_data = $urandom;
      flush   = ($urandom_range(0, 40) == 0);
      for (int k = 0; k < NRD; k++) begin
        rs_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? rd_addr
                                                          : AW'($urandom_range(0, DEPTH - 1));
      end
      cycle();
    end
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
